// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with rising-edge increment strobe, clamped amount and saturation.
// Optional high-score tracking is enabled by defining SCORE_HIGH_SCORE_EN.
module bcd_score_counter #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  inc_strobe,
  input  logic [3:0]            inc_amount,
  output logic [4*DIGITS-1:0]   score,
  output logic                  saturated,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  new_high
);

  localparam int            W         = 4 * DIGITS;
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] r_score;
  logic         r_saturated;
  logic         r_strobe_q;

  logic [3:0]   w_amt;
  logic [W-1:0] w_sum;
  logic         w_carry;
  logic [4:0]   w_digit_sum;
  logic         w_accept;

  assign w_amt    = (inc_amount > 4'd9) ? 4'd9 : inc_amount;
  assign w_accept = inc_strobe & ~r_strobe_q & run & ~clear & ~r_saturated;

  // Ripple-carry BCD add; the amount enters digit 0 only, higher digits add the carry.
  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_sum       = '0;
    w_carry     = 1'b0;
    w_digit_sum = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 0) w_digit_sum = {1'b0, r_score[3:0]} + {1'b0, w_amt};
      else        w_digit_sum = {1'b0, r_score[4*i +: 4]} + {4'b0, w_carry};
      if (w_digit_sum > 5'd9) begin
        w_digit_sum       = w_digit_sum - 5'd10;
        w_carry           = 1'b1;
      end else begin
        w_carry           = 1'b0;
      end
      w_sum[4*i +: 4] = w_digit_sum[3:0];
    end
  end

  // NOTE: reset is synchronous and sampled only on the clock edge; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_score     <= '0;
      r_saturated <= 1'b0;
      r_strobe_q  <= 1'b0;
    end else begin
      r_strobe_q <= inc_strobe;
      if (clear) begin
        r_score     <= '0;
        r_saturated <= 1'b0;
      end else if (w_accept) begin
        if (w_carry) begin
          r_score     <= ALL_NINES;
          r_saturated <= 1'b1;
        end else begin
          r_score <= w_sum;
          if (w_sum == ALL_NINES) r_saturated <= 1'b1;
        end
      end
    end
  end

  assign score     = r_score;
  assign saturated = r_saturated;

`ifdef SCORE_HIGH_SCORE_EN
  logic [W-1:0] r_high_score;
  logic         r_new_high;

  // Packed BCD compares correctly as unsigned since every digit stays in 0..9.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_high_score <= '0;
      r_new_high   <= 1'b0;
    end else if (r_score > r_high_score) begin
      r_high_score <= r_score;
      r_new_high   <= 1'b1;
    end else begin
      r_new_high   <= 1'b0;
    end
  end

  assign high_score = r_high_score;
  assign new_high   = r_new_high;
`else
  assign high_score = '0;
  assign new_high   = 1'b0;
`endif

endmodule
